player_box_drawer: RTL and testbench
====================================

// Module: player_box_drawer
// PURPOSE
//  Pixel-write generator for the obstacle-course game; drives the VGA adapter's x/y/colour/plot port.
//  Holds one player box and moves it 1 px per frame tick under button control.
//  On each move it erases the old box in background colour, then draws the box at the new position.
//  Feeds the 160x120, 3-bit-colour framebuffer; the background image is preloaded by the adapter.
// PARAMETERS
//  BOX_W        4        box width, pixels (1..16)
//  BOX_H        4        box height, pixels (1..16)
//  FRAME_DIV    833333   clk cycles per frame tick (60 Hz at 50 MHz); >= 2*BOX_W*BOX_H+4
//  START_X      78       x of box top-left after reset
//  START_Y      58       y of box top-left after reset
//  PLAYER_COL   3'b100   box colour
//  BG_COL       3'b111   erase colour
// PORTS
//  clk         in   1  system clock (CLOCK_50)
//  resetn      in   1  asynchronous, active-low reset
//  move_up     in   1  level, sampled at UPDATE
//  move_down   in   1  level, sampled at UPDATE
//  move_left   in   1  level, sampled at UPDATE
//  move_right  in   1  level, sampled at UPDATE
//  xpos        out  8  pixel x to the adapter
//  ypos        out  7  pixel y to the adapter
//  color       out  3  pixel colour to the adapter
//  plot        out  1  write strobe, one pixel per cycle while high
//  busy        out  1  high during INIT/ERASE/DRAW
//  frame_done  out  1  one-cycle pulse when a DRAW pass completes
// BEHAVIOUR
//  Reset: xpos=0, ypos=0, color=0, plot=0, busy=0, frame_done=0; box pos = (START_X, START_Y);
//   tick counter=0; pending=0; state=INIT. All outputs registered.
//  FSM: INIT -> DRAW (initial paint, no tick needed); WAIT -> UPDATE on tick or pending;
//   UPDATE -> ERASE if the new position differs from the old, else WAIT (no plot); ERASE -> DRAW -> WAIT.
//  UPDATE (1 cycle): dx = right-left, dy = down-up. Left+right together gives dx=0; up+down gives dy=0.
//   Diagonal moves allowed. New x clamped to [0, 160-BOX_W]; new y clamped to [0, 120-BOX_H].
//   Old position kept for ERASE; new position committed at ERASE->DRAW.
//  ERASE/DRAW: col/row counters scan raster order, col fastest. Exactly BOX_W*BOX_H plot cycles each.
//   xpos = base_x+col, ypos = base_y+row, color = BG_COL (ERASE) or PLAYER_COL (DRAW).
//   plot is low in every other state. There are no gap cycles between ERASE and DRAW.
//  Tick: free-running counter wraps at FRAME_DIV-1 and emits a 1-cycle tick. A tick arriving
//   outside WAIT sets pending (one deep); further ticks while pending=1 are dropped. UPDATE clears pending.
//  frame_done pulses the cycle after the last DRAW pixel. busy drops the same cycle.
//  resetn low mid-pass: plot falls immediately (async); the pass is abandoned; INIT repaints at START.
// CONFIGURATION
//  TRAIL_EN defined: ERASE is skipped (UPDATE->DRAW when moved); the box leaves a trail.
//  TRAIL_EN undefined: full erase-then-draw as above.
// STRUCTURE
//  package player_draw_pkg: SCREEN_W=160, SCREEN_H=120, colour constants, state enum
//   {INIT, WAIT, UPDATE, ERASE, DRAW}.
//  sub-module frame_tick_gen (FRAME_DIV counter -> tick). Scan counters and FSM stay in this module.
// TESTING (FRAME_DIV=64 for sim)
//  Reset release -> 16 plots, x 78..81 and y 58..61, color 100, row-major; then frame_done=1 for 1 cycle.
//  move_right held, one tick -> 16 plots color 111 at x78..81, then 16 plots color 100 at x79..82.
//  Box at x=156, move_right held, tick -> no plot, busy stays 0, position unchanged.
//  move_left+move_right+move_down, tick -> erase at y58..61, draw at y59..62, x unchanged.
//  resetn asserted after 5th DRAW pixel -> plot=0 async; on release, INIT repaints at (78,58).
//  TRAIL_EN, move_up, tick -> no color-111 writes; 16 draws at y57..60.

Source files
------------

// File: rtl/player_draw_pkg.sv
// Shared screen geometry, default colours, FSM state type and the
// clamped one-pixel step helper for the player box drawer.
package player_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_PLAYER = 3'b100;
  localparam logic [2:0] COL_BG     = 3'b111;

  typedef enum logic [2:0] {
    INIT,
    WAIT,
    UPDATE,
    ERASE,
    DRAW
  } state_t;

  // One step toward inc or dec, held inside [0, max_pos]; opposing buttons cancel.
  function automatic logic [7:0] step_clamp(input logic [7:0] pos,
                                            input logic       inc,
                                            input logic       dec,
                                            input logic [7:0] max_pos);
    if (inc && !dec && pos < max_pos) return pos + 8'd1;
    if (dec && !inc && pos != 8'd0)   return pos - 8'd1;
    return pos;
  endfunction

endpackage

// File: rtl/player_box_drawer_if.sv
// Button inputs and VGA-adapter pixel port of the player box drawer.
// master: the drawer side; slave: the adapter/button side.
interface player_box_drawer_if;

  logic       move_up;
  logic       move_down;
  logic       move_left;
  logic       move_right;
  logic [7:0] xpos;
  logic [6:0] ypos;
  logic [2:0] color;
  logic       plot;
  logic       busy;
  logic       frame_done;

  modport master (
    input  move_up, move_down, move_left, move_right,
    output xpos, ypos, color, plot, busy, frame_done
  );

  modport slave (
    output move_up, move_down, move_left, move_right,
    input  xpos, ypos, color, plot, busy, frame_done
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clock cycles.
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int             CW   = $clog2(FRAME_DIV);
  localparam logic [CW-1:0]  LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/player_box_drawer.sv
// Player box pixel-write generator: erases the old box and draws the new one on each move.
// Define TRAIL_EN to skip the erase pass so the box leaves a trail.
module player_box_drawer
  import player_draw_pkg::*;
#(
  parameter int         BOX_W      = 4,
  parameter int         BOX_H      = 4,
  parameter int         FRAME_DIV  = 833333,
  parameter int         START_X    = 78,
  parameter int         START_Y    = 58,
  parameter logic [2:0] PLAYER_COL = COL_PLAYER,
  parameter logic [2:0] BG_COL     = COL_BG
) (
  input  logic                       clk,
  input  logic                       resetn,
  player_box_drawer_if.master        bus
);

  localparam logic [7:0] MAX_X    = 8'(SCREEN_W - BOX_W);
  localparam logic [7:0] MAX_Y    = 8'(SCREEN_H - BOX_H);
  localparam logic [3:0] LAST_COL = 4'(BOX_W - 1);
  localparam logic [3:0] LAST_ROW = 4'(BOX_H - 1);

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [7:0] pos_x_q, pos_x_d, tgt_x_q, tgt_x_d, move_x;
  logic [6:0] pos_y_q, pos_y_d, tgt_y_q, tgt_y_d, move_y;
  logic       pending_q, pending_d;
  logic       tick, scan_last, done_d, plot_d, busy_d;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  assign move_x    = step_clamp(pos_x_q, bus.move_right, bus.move_left, MAX_X);
  assign move_y    = 7'(step_clamp({1'b0, pos_y_q}, bus.move_down, bus.move_up, MAX_Y));
  assign scan_last = (col_q == LAST_COL) && (row_q == LAST_ROW);

  // A tick that lands while a pass is running is remembered once; UPDATE consumes it.
  assign pending_d = (pending_q && state_q != UPDATE) || (tick && state_q != WAIT);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    done_d  = 1'b0;

    unique case (state_q)
      INIT: begin
        state_d = DRAW;
        col_d   = '0;
        row_d   = '0;
      end
      WAIT: begin
        if (tick || pending_q) state_d = UPDATE;
      end
      UPDATE: begin
        tgt_x_d = move_x;
        tgt_y_d = move_y;
        col_d   = '0;
        row_d   = '0;
        if (move_x != pos_x_q || move_y != pos_y_q) begin
`ifdef TRAIL_EN
          state_d = DRAW;
          pos_x_d = move_x;
          pos_y_d = move_y;
`else
          state_d = ERASE;
`endif
        end else begin
          state_d = WAIT;
        end
      end
      ERASE, DRAW: begin
        if (scan_last) begin
          col_d = '0;
          row_d = '0;
          if (state_q == ERASE) begin
            state_d = DRAW;
            pos_x_d = tgt_x_q;
            pos_y_d = tgt_y_q;
          end else begin
            state_d = WAIT;
            done_d  = 1'b1;
          end
        end else if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      default: state_d = INIT;
    endcase

    plot_d = (state_d == ERASE) || (state_d == DRAW);
    busy_d = plot_d || (state_d == INIT);
  end

  // Outputs are loaded from next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= INIT;
      col_q          <= '0;
      row_q          <= '0;
      pos_x_q        <= 8'(START_X);
      pos_y_q        <= 7'(START_Y);
      tgt_x_q        <= 8'(START_X);
      tgt_y_q        <= 7'(START_Y);
      pending_q      <= 1'b0;
      bus.xpos       <= '0;
      bus.ypos       <= '0;
      bus.color      <= '0;
      bus.plot       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      tgt_x_q        <= tgt_x_d;
      tgt_y_q        <= tgt_y_d;
      pending_q      <= pending_d;
      bus.plot       <= plot_d;
      bus.busy       <= busy_d;
      bus.frame_done <= done_d;
      if (plot_d) begin
        bus.xpos  <= pos_x_d + {4'b0, col_d};
        bus.ypos  <= pos_y_d + {3'b0, row_d};
        bus.color <= (state_d == ERASE) ? BG_COL : PLAYER_COL;
      end
    end
  end

endmodule

// File: tb/tb_player_box_drawer.sv
// Self-checking bench for player_box_drawer: vector table, edge runs, random moves, reset mid-pass.
module tb_player_box_drawer;

  localparam int BOX_W   = 4;
  localparam int BOX_H   = 4;
  localparam int DIV     = 64;
  localparam int START_X = 78;
  localparam int START_Y = 58;
  localparam int MAX_X   = 160 - BOX_W;
  localparam int MAX_Y   = 120 - BOX_H;
  localparam logic [2:0] C_PLAYER = 3'b100;
  localparam logic [2:0] C_BG     = 3'b111;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic u, d, l, r;
    int   dx, dy;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  player_box_drawer_if bus ();

  player_box_drawer #(
    .BOX_W(BOX_W), .BOX_H(BOX_H), .FRAME_DIV(DIV),
    .START_X(START_X), .START_Y(START_Y),
    .PLAYER_COL(C_PLAYER), .BG_COL(C_BG)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mx, my;
  pix_t exp_q[$];
  pix_t got_q[$];
  int   got_done, got_busy;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_box(input int bx, input int by, input logic [2:0] c);
    for (int r = 0; r < BOX_H; r++)
      for (int k = 0; k < BOX_W; k++)
        exp_q.push_back('{x: 8'(bx + k), y: 7'(by + r), c: c});
  endtask

  // Reference: new position is old + (right-left, down-up), clamped to the screen.
  task automatic model_move(input int dx, input int dy);
    int nx, ny;
    nx = mx + dx;
    ny = my + dy;
    if (nx < 0) nx = 0;
    if (nx > MAX_X) nx = MAX_X;
    if (ny < 0) ny = 0;
    if (ny > MAX_Y) ny = MAX_Y;
    exp_q.delete();
    if (nx != mx || ny != my) begin
`ifndef TRAIL_EN
      add_box(mx, my, C_BG);
`endif
      add_box(nx, ny, C_PLAYER);
    end
    mx = nx;
    my = ny;
  endtask

  task automatic capture(input int cycles);
    got_q.delete();
    got_done = 0;
    got_busy = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.plot) got_q.push_back('{x: bus.xpos, y: bus.ypos, c: bus.color});
      if (bus.frame_done) got_done++;
      if (bus.busy) got_busy++;
    end
  endtask

  task automatic compare_pass(input string tag);
    check({tag, "_plots"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(got_done), (exp_q.size() != 0) ? 32'd1 : 32'd0);
    check({tag, "_busy"}, 32'(got_busy), 32'(exp_q.size()));
  endtask

  // Buttons change one window ahead of the tick, so they are stable at UPDATE.
  task automatic run_step(input logic u, input logic d, input logic l, input logic r,
                          input int dx, input int dy, input string tag);
    bus.move_up    = u;
    bus.move_down  = d;
    bus.move_left  = l;
    bus.move_right = r;
    model_move(dx, dy);
    capture(DIV);
    compare_pass(tag);
  endtask

  task automatic rule_step(input logic u, input logic d, input logic l, input logic r,
                           input string tag);
    run_step(u, d, l, r, int'(r) - int'(l), int'(d) - int'(u), tag);
  endtask

  initial begin
    int seen;
    logic [3:0] b;

    vecs[0] = '{u: 0, d: 0, l: 0, r: 1, dx:  1, dy:  0};
    vecs[1] = '{u: 0, d: 1, l: 1, r: 1, dx:  0, dy:  1};
    vecs[2] = '{u: 1, d: 1, l: 0, r: 0, dx:  0, dy:  0};
    vecs[3] = '{u: 1, d: 0, l: 1, r: 0, dx: -1, dy: -1};
    vecs[4] = '{u: 0, d: 0, l: 0, r: 0, dx:  0, dy:  0};
    vecs[5] = '{u: 0, d: 1, l: 1, r: 0, dx: -1, dy:  1};
    vecs[6] = '{u: 1, d: 1, l: 1, r: 1, dx:  0, dy:  0};

    bus.move_up = 0; bus.move_down = 0; bus.move_left = 0; bus.move_right = 0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plot",  32'(bus.plot), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.frame_done), 32'd0);
    check("rst_xpos",  32'(bus.xpos), 32'd0);
    check("rst_ypos",  32'(bus.ypos), 32'd0);
    check("rst_color", 32'(bus.color), 32'd0);

    // Abandon the initial paint after its fifth pixel.
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && seen < 5; i++) begin
      @(negedge clk);
      if (bus.plot) seen++;
    end
    check("mid_seen5", 32'(seen), 32'd5);
    resetn = 1'b0;
    #1;
    check("mid_plot_async", 32'(bus.plot), 32'd0);
    check("mid_busy_async", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    mx = START_X;
    my = START_Y;
    exp_q.delete();
    add_box(mx, my, C_PLAYER);
    capture(44);
    compare_pass("init");

    foreach (vecs[i])
      run_step(vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].dx, vecs[i].dy,
               $sformatf("vec%0d", i));

    for (int i = 0; i < 200 && mx < MAX_X; i++) rule_step(0, 0, 0, 1, "run_right");
    check("at_right_edge", 32'(mx), 32'(MAX_X));
    rule_step(0, 0, 0, 1, "clamp_right");
    for (int i = 0; i < 200 && my > 0; i++) rule_step(1, 0, 0, 0, "run_up");
    rule_step(1, 0, 0, 0, "clamp_top");

    for (int i = 0; i < 30; i++) begin
      b = 4'($urandom_range(0, 15));
      rule_step(b[3], b[2], b[1], b[0], $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
